// File: rtl/instr_enc_pkg.sv
// Instruction-encoding constants shared by the encoder, the control unit and the testbench:
// op_kind encoding, opcode values and the 2-entry FIFO fill states.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        OPK_R    = 3'd0,
        OPK_LW   = 3'd1,
        OPK_SW   = 3'd2,
        OPK_BEQ  = 3'd3,
        OPK_ADDI = 3'd4,
        OPK_J    = 3'd5
    } op_kind_e;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_J    = 6'h02;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_e;

    // op_kind 6 and 7 are reserved and have no encoding.
    function automatic logic is_legal_kind(input logic [2:0] kind);
        return kind <= 3'd5;
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry first-word-fall-through buffer; the fill level (EMPTY/ONE/FULL) is the FSM state.
module enc_fifo2
    import instr_enc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              not_full,
    output logic              not_empty
);

    fill_e             state;
    fill_e             next_state;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              do_push;
    logic              do_pop;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= FILL_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        not_full   = 1'b1;
        not_empty  = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        case (state)
            FILL_EMPTY: begin
                do_push = push;
                if (push) next_state = FILL_ONE;
            end
            FILL_ONE: begin
                not_empty = 1'b1;
                do_push   = push;
                do_pop    = pop;
                if (push && !pop) begin
                    next_state = FILL_FULL;
                end else if (!push && pop) begin
                    next_state = FILL_EMPTY;
                end
            end
            FILL_FULL: begin
                not_full  = 1'b0;
                not_empty = 1'b1;
                do_pop    = pop;
                if (pop) next_state = FILL_ONE;
            end
            default: next_state = FILL_EMPTY;
        endcase
    end

    // head is always the oldest word; tail only holds data while FULL.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head <= '0;
            tail <= '0;
        end else if (do_pop) begin
            if (state == FILL_FULL) begin
                head <= tail;
            end else if (do_push) begin
                head <= din;
            end
        end else if (do_push) begin
            if (state == FILL_EMPTY) begin
                head <= din;
            end else begin
                tail <= din;
            end
        end
    end

    assign dout = head;

endmodule

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding an instruction-memory write port through a 2-entry FIFO.
// Define ENC_ILLEGAL_TRAP_EN to trap op_kind 6-7 into a sticky err flag instead of emitting a NOP.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    logic [31:0] enc_word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_not_full;
    logic        fifo_not_empty;

    always_comb begin
        enc_word = NOP_WORD;
        case (op_kind)
            OPK_R:    enc_word = {OPC_R, rs, rt, rd, shamt, funct};
            OPK_LW:   enc_word = {OPC_LW, rs, rt, imm};
            OPK_SW:   enc_word = {OPC_SW, rs, rt, imm};
            OPK_BEQ:  enc_word = {OPC_BEQ, rs, rt, imm};
            OPK_ADDI: enc_word = {OPC_ADDI, rs, rt, imm};
            OPK_J:    enc_word = {OPC_J, target};
            default:  enc_word = NOP_WORD;
        endcase
    end

    assign in_ready  = fifo_not_full;
    assign out_valid = fifo_not_empty;
    assign accept    = in_valid & fifo_not_full;
    assign pop       = fifo_not_empty & out_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic illegal;

    assign illegal = ~is_legal_kind(op_kind);
    assign push    = accept & ~illegal;

    // A trapped request is still accepted (handshake completes) but never reaches the FIFO.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err <= 1'b0;
        end else if (accept && illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    enc_fifo2 #(
        .DATA_W(32)
    ) u_fifo (
        .clk      (clk),
        .arst     (arst),
        .push     (push),
        .pop      (pop),
        .din      (enc_word),
        .dout     (out_data),
        .not_full (fifo_not_full),
        .not_empty(fifo_not_empty)
    );

    // A base load wins over the post-pop increment so software can retarget mid-stream.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_addr <= '0;
        end else if (base_load) begin
            out_addr <= base_addr;
        end else if (pop) begin
            out_addr <= out_addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model compared every cycle,
// directed sequences with hand-computed words, then randomized traffic.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              arst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_kind;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic              exp_err  = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .arst     (arst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_kind  (op_kind),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm      (imm),
        .target   (target),
        .base_load(base_load),
        .base_addr(base_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .err      (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Field weights: op at bit 26, rs 21, rt 16, rd 11, shamt 6.
    function automatic logic [31:0] model_word(input int unsigned k, input int unsigned a_rs,
                                               input int unsigned a_rt, input int unsigned a_rd,
                                               input int unsigned a_sh, input int unsigned a_fn,
                                               input int unsigned a_imm, input int unsigned a_tg);
        int unsigned op;
        int unsigned w;
        case (k)
            0: op = OPC_R;
            1: op = OPC_LW;
            2: op = OPC_SW;
            3: op = OPC_BEQ;
            4: op = OPC_ADDI;
            5: op = OPC_J;
            default: op = 0;
        endcase
        if (k == 0)
            w = op * 32'h0400_0000 + a_rs * 32'h0020_0000 + a_rt * 32'h0001_0000
              + a_rd * 32'h800 + a_sh * 32'h40 + a_fn;
        else if (k == 5)
            w = op * 32'h0400_0000 + a_tg;
        else if (k <= 4)
            w = op * 32'h0400_0000 + a_rs * 32'h0020_0000 + a_rt * 32'h0001_0000 + a_imm;
        else
            w = 0;
        return w;
    endfunction

    // Reference model: occupancy is the queue length, pops and pushes are decided from pre-edge state.
    always @(posedge clk or posedge arst) begin
        bit acc;
        bit pop_now;
        if (arst) begin
            exp_q.delete();
            exp_addr = '0;
            exp_err  = 1'b0;
        end else begin
            acc     = in_valid && (exp_q.size() < 2);
            pop_now = out_ready && (exp_q.size() > 0);
            if (pop_now) void'(exp_q.pop_front());
            if (acc) begin
                if (op_kind >= 3'd6) begin
`ifdef ENC_ILLEGAL_TRAP_EN
                    exp_err = 1'b1;
`else
                    exp_q.push_back(32'h0);
`endif
                end else begin
                    exp_q.push_back(model_word(op_kind, rs, rt, rd, shamt, funct, imm, target));
                end
            end
            if (base_load) exp_addr = base_addr;
            else if (pop_now) exp_addr = exp_addr + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
            checkOutput("err", {31'b0, err}, {31'b0, exp_err});
            checkOutput("out_addr", {24'b0, out_addr}, {24'b0, exp_addr});
            if (exp_q.size() != 0) checkOutput("out_data", out_data, exp_q[0]);
        end
    end

    task automatic applyStimulus(input logic [2:0] k, input logic [4:0] a_rs, input logic [4:0] a_rt,
                                 input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                                 input logic [15:0] a_imm, input logic [25:0] a_tg);
        logic rdy;
        int   cycles;
        op_kind  = k;
        rs       = a_rs;
        rt       = a_rt;
        rd       = a_rd;
        shamt    = a_sh;
        funct    = a_fn;
        imm      = a_imm;
        target   = a_tg;
        in_valid = 1'b1;
        cycles   = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            cycles++;
        end while (!rdy && cycles < 20);
        checkOutput("accept_within_budget", {31'b0, rdy}, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic resetDut();
        arst = 1'b1;
        @(negedge clk);
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst = 1'b1;
        in_valid = 1'b0; op_kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
        funct = '0; imm = '0; target = '0; base_load = 1'b0; base_addr = '0; out_ready = 1'b0;

        #12;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_out_addr", {24'b0, out_addr}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        check_en = 1'b1;
        #1 arst = 1'b0;
        @(posedge clk);
        #1;

        // ADDI right after reset
        out_ready = 1'b1;
        applyStimulus(OPK_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
        @(negedge clk);
        checkOutput("addi_word", out_data, 32'h2022_0005);
        checkOutput("addi_addr", {24'b0, out_addr}, 32'd0);
        @(posedge clk); #1;

        // back-to-back R-type then LW
        resetDut();
        out_ready = 1'b1;
        applyStimulus(OPK_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
        fork
            applyStimulus(OPK_LW, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
            begin
                @(negedge clk);
                checkOutput("rtype_word", out_data, 32'h0022_1820);
                checkOutput("rtype_addr", {24'b0, out_addr}, 32'd0);
            end
        join
        @(negedge clk);
        checkOutput("lw_word", out_data, 32'h8C08_0004);
        checkOutput("lw_addr", {24'b0, out_addr}, 32'd1);
        @(posedge clk); #1;

        // backpressure: fill both slots, third waits for a free slot
        resetDut();
        out_ready = 1'b0;
        applyStimulus(OPK_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        applyStimulus(OPK_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        fork
            applyStimulus(OPK_ADDI, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0);
            begin
                @(negedge clk);
                checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
                checkOutput("full_head_j", out_data, 32'h0800_0010);
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                checkOutput("release_head_j", out_data, 32'h0800_0010);
                @(negedge clk);
                checkOutput("second_beq", out_data, 32'h1022_FFFF);
                checkOutput("slot_freed", {31'b0, in_ready}, 32'd1);
                @(negedge clk);
                checkOutput("third_addi", out_data, 32'h2064_0007);
            end
        join
        @(posedge clk); #1;

        // address wrap and base_load priority over pop
        resetDut();
        out_ready = 1'b0;
        base_load = 1'b1; base_addr = 8'hFF;
        @(posedge clk); #1 base_load = 1'b0;
        applyStimulus(OPK_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd1);
        applyStimulus(OPK_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd2);
        @(negedge clk);
        checkOutput("base_addr_ff", {24'b0, out_addr}, 32'hFF);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("first_pop_data", out_data, 32'h0800_0001);
        @(negedge clk);
        checkOutput("wrap_addr", {24'b0, out_addr}, 32'h00);
        checkOutput("wrap_data", out_data, 32'h0800_0002);
        @(posedge clk); #1 out_ready = 1'b0;
        applyStimulus(OPK_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd3);
        out_ready = 1'b1; base_load = 1'b1; base_addr = 8'h40;
        @(posedge clk); #1 base_load = 1'b0;
        @(negedge clk);
        checkOutput("load_beats_pop", {24'b0, out_addr}, 32'h40);
        checkOutput("load_pop_empty", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // unsupported op_kind
        resetDut();
        out_ready = 1'b0;
        applyStimulus(3'd7, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'h1234, 26'h3FF_FFFF);
        @(negedge clk);
`ifdef ENC_ILLEGAL_TRAP_EN
        checkOutput("trap_err", {31'b0, err}, 32'd1);
        checkOutput("trap_not_pushed", {31'b0, out_valid}, 32'd0);
`else
        checkOutput("nop_err", {31'b0, err}, 32'd0);
        checkOutput("nop_pushed", {31'b0, out_valid}, 32'd1);
        checkOutput("nop_word", out_data, 32'h0);
`endif
        @(posedge clk); #1;

        // asynchronous reset while FULL
        resetDut();
        out_ready = 1'b0;
        base_load = 1'b1; base_addr = 8'h33;
        @(posedge clk); #1 base_load = 1'b0;
        applyStimulus(OPK_SW, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        applyStimulus(OPK_LW, 5'd5, 5'd7, 5'd0, 5'd0, 6'd0, 16'h0020, 26'd0);
        @(negedge clk);
        checkOutput("pre_reset_full", {31'b0, in_ready}, 32'd0);
        #2 arst = 1'b1;
        #1;
        checkOutput("async_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("async_out_addr", {24'b0, out_addr}, 32'd0);
        #1 arst = 1'b0;
        @(posedge clk); #1;

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op_kind   = 3'($urandom_range(0, 7));
            rs        = 5'($urandom);
            rt        = 5'($urandom);
            rd        = 5'($urandom);
            shamt     = 5'($urandom);
            funct     = 6'($urandom);
            imm       = 16'($urandom);
            target    = 26'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            base_load = ($urandom_range(0, 15) == 0);
            base_addr = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drained", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
